// File: rtl/char_ram_pkg.sv
// ---------------------------------------------------------------------------
// char_ram_pkg
// Shared definitions for the character-RAM write arbiter: screen geometry,
// RAM port widths, arbiter state encoding and the spawn request record that
// the spawn FIFO stores.
// ---------------------------------------------------------------------------
package char_ram_pkg;

  localparam int CELLS_DEFAULT = 2100;  // 70 x 30 cells
  localparam int COLS          = 70;
  localparam int ROWS          = 30;
  localparam int ADDR_W        = 12;
  localparam int DATA_W        = 8;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spawn_req_t;

endpackage

// File: rtl/char_ram_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// char_ram_wr_arbiter_if
// Request/grant and RAM-write bundle of the character-RAM write arbiter.
//   master : game side + RAM side (drives requests, observes grants/writes)
//   slave  : the arbiter
// Signals:
//   sweep_start            clear-screen pulse
//   hit_valid/addr/ready   keyboard-hit clear handshake
//   spawn_valid/addr/data/ready  spawn write handshake (FIFO backed)
//   wren/wraddr/wdata      single RAM write port
//   sweep_busy, hit_ack    status / score pulse
// Optional macro ARB_STATS_EN adds stat_hits, stat_spawns, stat_drops.
// ---------------------------------------------------------------------------
interface char_ram_wr_arbiter_if;
  import char_ram_pkg::*;

  logic              sweep_start;
  logic              hit_valid;
  logic [ADDR_W-1:0] hit_addr;
  logic              hit_ready;
  logic              spawn_valid;
  logic [ADDR_W-1:0] spawn_addr;
  logic [DATA_W-1:0] spawn_data;
  logic              spawn_ready;
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic [DATA_W-1:0] wdata;
  logic              sweep_busy;
  logic              hit_ack;

`ifdef ARB_STATS_EN
  logic [15:0]       stat_hits;
  logic [15:0]       stat_spawns;
  logic [15:0]       stat_drops;

  modport slave (
    input  sweep_start, hit_valid, hit_addr, spawn_valid, spawn_addr, spawn_data,
    output hit_ready, spawn_ready, wren, wraddr, wdata, sweep_busy, hit_ack,
    output stat_hits, stat_spawns, stat_drops
  );
  modport master (
    output sweep_start, hit_valid, hit_addr, spawn_valid, spawn_addr, spawn_data,
    input  hit_ready, spawn_ready, wren, wraddr, wdata, sweep_busy, hit_ack,
    input  stat_hits, stat_spawns, stat_drops
  );
`else
  modport slave (
    input  sweep_start, hit_valid, hit_addr, spawn_valid, spawn_addr, spawn_data,
    output hit_ready, spawn_ready, wren, wraddr, wdata, sweep_busy, hit_ack
  );
  modport master (
    output sweep_start, hit_valid, hit_addr, spawn_valid, spawn_addr, spawn_data,
    input  hit_ready, spawn_ready, wren, wraddr, wdata, sweep_busy, hit_ack
  );
`endif

endinterface

// File: rtl/char_ram_wr_arbiter_spawn_fifo.sv
// ---------------------------------------------------------------------------
// spawn_fifo
// Small synchronous first-word-fall-through FIFO of spawn requests.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   flush          drop all stored entries (a same-cycle push is still kept)
//   push, push_req write request (ignored when full)
//   pop            discard head (ignored when empty)
//   head           current head entry, valid while !empty
//   full, empty    occupancy flags (registered count, not bypassed)
// ---------------------------------------------------------------------------
module spawn_fifo
  import char_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  spawn_req_t push_req,
  input  logic       pop,
  output spawn_req_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  spawn_req_t       mem_q [FIFO_DEPTH];
  spawn_req_t       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      // Old contents vanish; a push accepted this cycle lands in slot 0.
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      if (do_push) begin
        mem_d[0] = push_req;
        wptr_d   = PTR_W'(1);
        cnt_d    = CNT_W'(1);
      end
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_req;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/char_ram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// char_ram_wr_arbiter
// Owns the single write port of the 70x30 character RAM and serialises three
// sources onto it, one write per clock:
//   - full-screen clear sweep (after reset and on sweep_start),
//   - keyboard-hit clears (highest priority, combinational hit_ready),
//   - spawn/scroll writes queued in spawn_fifo.
// A run of MAX_HIT_RUN hit grants with spawns waiting forces one spawn slot.
// Writes appear on wren/wraddr/wdata one clock after the grant; hit_ack
// pulses together with the write of an in-range hit.
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high
//   bus    char_ram_wr_arbiter_if.slave (handshakes, RAM write port, status)
// Optional macro ARB_STATS_EN: saturating 16-bit hit/spawn/drop counters.
// ---------------------------------------------------------------------------
module char_ram_wr_arbiter
  import char_ram_pkg::*;
#(
  parameter int CELLS       = CELLS_DEFAULT,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_HIT_RUN = 8
) (
  input logic                  clk,
  input logic                  reset,
  char_ram_wr_arbiter_if.slave bus
);

  localparam int RUN_W = (MAX_HIT_RUN < 1) ? 1 : $clog2(MAX_HIT_RUN + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_HIT_RUN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_C   = (ADDR_W + 1)'(CELLS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CELLS_C;
  endfunction

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [RUN_W-1:0]  hit_run_q, hit_run_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_ack_q, hit_ack_d;

  spawn_req_t        fifo_head;
  spawn_req_t        push_req;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop, fifo_flush;

  logic              in_run, force_spawn, hit_ready, hit_grant;
  logic              restart, spawn_grant, collide;
  logic              hit_in_range, head_in_range;

  assign in_run        = (state_q == RUN);
  assign force_spawn   = (hit_run_q == RUN_MAX) && !fifo_empty;
  assign hit_ready     = in_run && !force_spawn;
  assign hit_grant     = bus.hit_valid && hit_ready;
  assign restart       = in_run && bus.sweep_start;
  // The flush on restart wins over handing the head out this cycle.
  assign spawn_grant   = in_run && !fifo_empty && !hit_grant && !restart;
  // A hit on the head's cell makes the queued write stale: drop it.
  assign collide       = hit_grant && !fifo_empty && !restart &&
                         (fifo_head.addr == bus.hit_addr);
  assign hit_in_range  = in_range(bus.hit_addr);
  assign head_in_range = in_range(fifo_head.addr);

  assign fifo_push     = bus.spawn_valid;
  assign fifo_pop      = spawn_grant || collide;
  assign fifo_flush    = restart;
  assign push_req      = '{addr: bus.spawn_addr, data: bus.spawn_data};

  spawn_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_spawn_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_req (push_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    hit_run_d   = hit_run_q;
    wren_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wdata_d     = wdata_q;
    hit_ack_d   = 1'b0;

    case (state_q)
      SWEEP: begin
        wren_d   = 1'b1;
        wraddr_d = sweep_cnt_q;
        wdata_d  = '0;
        if (sweep_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (hit_grant) begin
          if (hit_in_range) begin
            wren_d    = 1'b1;
            wraddr_d  = bus.hit_addr;
            wdata_d   = '0;
            hit_ack_d = 1'b1;
          end
        end else if (spawn_grant) begin
          if (head_in_range) begin
            wren_d   = 1'b1;
            wraddr_d = fifo_head.addr;
            wdata_d  = fifo_head.data;
          end
        end

        // Hit run only counts while spawns are actually being held back.
        if (fifo_empty || spawn_grant) begin
          hit_run_d = '0;
        end else if (hit_grant) begin
          hit_run_d = hit_run_q + 1'b1;
        end

        if (restart) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
          hit_run_d   = '0;
        end
      end

      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      hit_run_q   <= '0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wdata_q     <= '0;
      hit_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      hit_run_q   <= hit_run_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wdata_q     <= wdata_d;
      hit_ack_q   <= hit_ack_d;
    end
  end

  assign bus.hit_ready   = hit_ready;
  assign bus.spawn_ready = !fifo_full;
  assign bus.sweep_busy  = (state_q == SWEEP);
  assign bus.wren        = wren_q;
  assign bus.wraddr      = wraddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.hit_ack     = hit_ack_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_hits_q, stat_hits_d;
  logic [15:0] stat_spawns_q, stat_spawns_d;
  logic [15:0] stat_drops_q, stat_drops_d;
  logic [1:0]  drop_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    // Drops: stale heads removed by a collision plus out-of-range requests.
    drop_inc      = {1'b0, collide} + {1'b0, hit_grant && !hit_in_range} +
                    {1'b0, spawn_grant && !head_in_range};
    stat_hits_d   = sat_add(stat_hits_q, {1'b0, hit_grant && hit_in_range});
    stat_spawns_d = sat_add(stat_spawns_q, {1'b0, spawn_grant && head_in_range});
    stat_drops_d  = sat_add(stat_drops_q, drop_inc);
    if (bus.sweep_start) begin
      stat_hits_d   = '0;
      stat_spawns_d = '0;
      stat_drops_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits_q   <= '0;
      stat_spawns_q <= '0;
      stat_drops_q  <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_spawns_q <= stat_spawns_d;
      stat_drops_q  <= stat_drops_d;
    end
  end

  assign bus.stat_hits   = stat_hits_q;
  assign bus.stat_spawns = stat_spawns_q;
  assign bus.stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_char_ram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_char_ram_wr_arbiter
// Directed scenarios plus a randomized phase. A transaction-level model
// (queue of pending spawns, sweep position, hit-run count) predicts the
// write port and ready/busy flags; one negedge process compares every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_char_ram_wr_arbiter;

  localparam int CELLS  = 2100;
  localparam int DEPTH  = 4;
  localparam int MAXRUN = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  char_ram_wr_arbiter_if bus();

  char_ram_wr_arbiter #(
    .CELLS       (CELLS),
    .FIFO_DEPTH  (DEPTH),
    .MAX_HIT_RUN (MAXRUN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int addr; int data; } req_t;
  req_t mq[$];
  bit   m_sweep;
  int   m_addr;
  int   m_run;
  bit   e_wren, e_ack;
  int   e_wraddr, e_wdata;
  bit   chk_en = 1'b0;

  task automatic model_step();
    int n, ha;
    bit hr, hit_acc, push, restart, spawn_g, drop_head;
    n         = mq.size();
    hr        = !m_sweep && !(m_run == MAXRUN && n > 0);
    hit_acc   = bus.hit_valid && hr;
    push      = bus.spawn_valid && (n < DEPTH);
    ha        = int'(bus.hit_addr);
    restart   = !m_sweep && bus.sweep_start;
    spawn_g   = 1'b0;
    drop_head = 1'b0;
    e_wren    = 1'b0;
    e_ack     = 1'b0;
    if (m_sweep) begin
      e_wren = 1'b1; e_wraddr = m_addr; e_wdata = 0;
      m_addr++;
      if (m_addr == CELLS) begin m_sweep = 1'b0; m_addr = 0; end
    end else begin
      if (hit_acc) begin
        if (ha < CELLS) begin e_wren = 1'b1; e_wraddr = ha; e_wdata = 0; e_ack = 1'b1; end
        drop_head = (n > 0) && !restart && (mq[0].addr == ha);
      end else if (n > 0 && !restart) begin
        spawn_g = 1'b1;
        if (mq[0].addr < CELLS) begin
          e_wren = 1'b1; e_wraddr = mq[0].addr; e_wdata = mq[0].data;
        end
      end
      if (n == 0 || spawn_g) m_run = 0;
      else if (hit_acc)     m_run++;
      if (spawn_g || drop_head) void'(mq.pop_front());
      if (restart) begin mq.delete(); m_sweep = 1'b1; m_addr = 0; m_run = 0; end
    end
    if (push) mq.push_back('{int'(bus.spawn_addr), int'(bus.spawn_data)});
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_sweep = 1'b1; m_addr = 0; m_run = 0;
      e_wren = 1'b0; e_ack = 1'b0; e_wraddr = 0; e_wdata = 0;
      chk_en = 1'b1;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wren", 32'(bus.wren), 32'(e_wren));
      chk("hit_ack", 32'(bus.hit_ack), 32'(e_ack));
      if (e_wren) begin
        chk("wraddr", 32'(bus.wraddr), 32'(e_wraddr));
        chk("wdata", 32'(bus.wdata), 32'(e_wdata));
      end
      chk("sweep_busy", 32'(bus.sweep_busy), 32'(m_sweep));
      chk("hit_ready", 32'(bus.hit_ready), 32'(!m_sweep && !(m_run == MAXRUN && mq.size() > 0)));
      chk("spawn_ready", 32'(bus.spawn_ready), 32'(mq.size() < DEPTH));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sweep_start = 1'b0;
    bus.hit_valid   = 1'b0;
    bus.hit_addr    = '0;
    bus.spawn_valid = 1'b0;
    bus.spawn_addr  = '0;
    bus.spawn_data  = '0;
  endtask

  function automatic logic [11:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return 12'(2100 + $urandom_range(0, 1995));
    else if (r == 1) return 12'(2099);
    else             return 12'(600 + $urandom_range(0, 7));
  endfunction

  initial begin
    int bad, p, acks, faddr, nw, nz, hp;
    bit found, spr4_seen, acc;

    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk("reset_wren", 32'(bus.wren), 0);
    chk("reset_wraddr", 32'(bus.wraddr), 0);
    chk("reset_wdata", 32'(bus.wdata), 0);
    chk("reset_hit_ack", 32'(bus.hit_ack), 0);

    // Power-up sweep: addresses 0..2099, all zero.
    reset = 1'b0;
    chk("busy_after_reset", 32'(bus.sweep_busy), 1);
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      step();
      if (bus.wren !== 1'b1 || int'(bus.wraddr) != i || bus.wdata != 8'd0) bad++;
    end
    chk("sweep_sequence_bad", 32'(bad), 0);
    chk("sweep_busy_fall", 32'(bus.sweep_busy), 0);
    chk("hit_ready_after_sweep", 32'(bus.hit_ready), 1);
    step();
    chk("sweep_end_wren", 32'(bus.wren), 0);
    chk("hit_ready_run", 32'(bus.hit_ready), 1);

    // Single hits: in range then out of range.
    bus.hit_valid = 1'b1; bus.hit_addr = 12'd140;
    step();
    bus.hit_valid = 1'b0;
    chk("hit140_wren", 32'(bus.wren), 1);
    chk("hit140_wraddr", 32'(bus.wraddr), 140);
    chk("hit140_wdata", 32'(bus.wdata), 0);
    chk("hit140_ack", 32'(bus.hit_ack), 1);
    bus.hit_valid = 1'b1; bus.hit_addr = 12'd2100;
    step();
    bus.hit_valid = 1'b0;
    chk("hit2100_wren", 32'(bus.wren), 0);
    chk("hit2100_ack", 32'(bus.hit_ack), 0);
    step();

    // Five spawns pushed under continuous hits: forced slot after 8-hit run.
    p = 0; found = 1'b0; acks = 0; faddr = -1; spr4_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.hit_valid   = 1'b1;
      bus.hit_addr    = 12'(1000 + k);
      bus.spawn_valid = (p < 5);
      bus.spawn_addr  = 12'(75 + p);
      bus.spawn_data  = 8'(8'h61 + p);
      acc = bus.spawn_valid && bus.spawn_ready;
      step();
      if (acc) p++;
      if (p == 4 && !spr4_seen) begin
        spr4_seen = 1'b1;
        chk("spawn_ready_full", 32'(bus.spawn_ready), 0);
      end
      if (!found) begin
        if (bus.wren === 1'b1 && bus.wdata == 8'h61) begin found = 1'b1; faddr = int'(bus.wraddr); end
        else if (bus.hit_ack === 1'b1) acks++;
      end
    end
    chk("forced_spawn_seen", 32'(found), 1);
    chk("forced_spawn_addr", 32'(faddr), 75);
    chk("hits_before_forced", 32'(acks), 9);
    chk("all_five_pushed", 32'(p), 5);
    idle_inputs();
    repeat (10) step();

    // Collision: hit 300 against head 300.
    bus.hit_valid = 1'b1; bus.hit_addr = 12'd900;
    bus.spawn_valid = 1'b1; bus.spawn_addr = 12'd300; bus.spawn_data = 8'h41;
    step();
    bus.hit_addr = 12'd901;
    bus.spawn_addr = 12'd301; bus.spawn_data = 8'h42;
    step();
    bus.hit_addr = 12'd300; bus.spawn_valid = 1'b0;
    step();
    bus.hit_valid = 1'b0;
    chk("collide_wren", 32'(bus.wren), 1);
    chk("collide_wraddr", 32'(bus.wraddr), 300);
    chk("collide_wdata", 32'(bus.wdata), 0);
    step();
    chk("next_head_wraddr", 32'(bus.wraddr), 301);
    chk("next_head_wdata", 32'(bus.wdata), 32'h42);
    step();
    chk("collide_no_extra", 32'(bus.wren), 0);
    idle_inputs();
    repeat (4) step();

    // sweep_start with three queued spawns.
    for (int k = 0; k < 3; k++) begin
      bus.hit_valid = 1'b1; bus.hit_addr = 12'(1200 + k);
      bus.spawn_valid = 1'b1; bus.spawn_addr = 12'(500 + k); bus.spawn_data = 8'(8'h78 + k);
      step();
    end
    idle_inputs();
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    chk("restart_no_write", 32'(bus.wren), 0);
    nw = 0; nz = 0;
    for (int k = 0; k < 2110; k++) begin
      step();
      if (bus.wren === 1'b1) begin nw++; if (bus.wdata != 8'd0) nz++; end
    end
    chk("flush_sweep_writes", 32'(nw), 2100);
    chk("flush_no_spawn", 32'(nz), 0);

    // Reset in the middle of a sweep.
    bus.sweep_start = 1'b1;
    step();
    bus.sweep_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 1200 && !found; k++) begin
      step();
      if (bus.wren === 1'b1 && bus.wraddr == 12'd1000) found = 1'b1;
    end
    chk("reach_addr_1000", 32'(found), 1);
    reset = 1'b1;
    step();
    chk("abort_wren", 32'(bus.wren), 0);
    chk("abort_busy", 32'(bus.sweep_busy), 1);
    reset = 1'b0;
    step();
    chk("restart_addr0_wren", 32'(bus.wren), 1);
    chk("restart_addr0", 32'(bus.wraddr), 0);
    repeat (2100) step();

    // Randomized traffic with varying hit density.
    for (int i = 0; i < 3000; i++) begin
      hp = (i / 300) % 3;
      bus.hit_valid   = ($urandom_range(0, 3) < hp + 1);
      bus.hit_addr    = pick_addr();
      bus.spawn_valid = ($urandom_range(0, 1) == 0);
      bus.spawn_addr  = pick_addr();
      bus.spawn_data  = 8'($urandom_range(0, 255));
      bus.sweep_start = ($urandom_range(0, 1499) == 0);
      step();
    end
    idle_inputs();
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
